inst_queue: RTL and testbench
=============================

// Module: inst_queue
// PURPOSE
//  Prefetch buffer between the instruction fetch unit and the decode stage. It holds up
//  to DEPTH {pc, inst} pairs and uses a valid/ready handshake on both sides.
//  It backpressures fetch when full so the PC is held.
//  It is cleared in one cycle on a control-flow redirect (branch, jump or jr taken).
// PARAMETERS
//  DEPTH   4   number of entries; power of two, >= 2
//  ADDR_W  2   pointer width, $clog2(DEPTH); derived, do not override
// PORTS
//  clk       in   1         single clock; all state updates on posedge
//  reset     in   1         synchronous, active-high; wins over every other input
//  flush     in   1         redirect: discard all entries and any push this cycle
//  if_valid  in   1         fetch presents a valid pair
//  if_pc     in   32        PC of the fetched instruction
//  if_inst   in   32        fetched instruction word
//  if_ready  out  1         queue accepts a push this cycle; fetch holds PC when 0
//  id_valid  out  1         head entry valid for decode
//  id_pc     out  32        PC of the head entry
//  id_inst   out  32        instruction of the head entry
//  id_ready  in   1         decode consumes the head this cycle
//  iq_count  out  ADDR_W+1  occupancy, 0..DEPTH
// BEHAVIOUR
//  - Reset: wr_ptr=rd_ptr=0, count=0, id_valid=0, id_pc=0, id_inst=`IQ_NOP, if_ready=1.
//    Storage contents are don't-care.
//  - push = if_valid & if_ready & ~flush; pop = id_valid & id_ready.
//  - if_ready = (count != DEPTH). It does not depend on id_ready: a full queue refuses pushes
//    even when a pop happens in the same cycle.
//  - id_valid = (count != 0) & ~flush.
//  - When id_valid=0, id_pc=0 and id_inst=`IQ_NOP. Otherwise they show mem[rd_ptr].
//  - Push: mem[wr_ptr] <= {if_pc, if_inst}; wr_ptr+1 wraps modulo DEPTH.
//  - Pop: rd_ptr+1 wraps modulo DEPTH.
//  - count update: +1 on push only; -1 on pop only; unchanged on push&pop; never exceeds DEPTH
//    and never goes below 0.
//  - Latency: a pair pushed in cycle N is visible at the head in cycle N+1 at the earliest.
//  - Order: strict FIFO; no entry is reordered or duplicated.
//  - Flush in cycle N:
//    - At posedge ending N: pointers=0, count=0.
//    - The push offered in cycle N is dropped.
//    - No pop is reported in cycle N, since id_valid=0.
//    - Cycle N+1 behaves like empty: if_ready=1, id_valid=0.
//  - Reset and flush together: reset semantics (identical end state).
//  - Reset mid-operation: all entries are lost; the same state as power-on reset.
// CONFIGURATION
//  INST_QUEUE_BYPASS_EN:
//   - Defined, count==0, if_valid=1, ~flush: id_valid=1 and id_pc/id_inst = if_pc/if_inst
//     combinationally (zero-latency).
//   - If id_ready is also 1, the pair is consumed with no write (count unchanged).
//   - If id_ready=0, the pair is pushed normally.
//   - Undefined: the minimum latency is 1 cycle, as described above.
// STRUCTURE
//  - defines.v gets `IQ_NOP (32'h0000_0000) and `IQ_DEPTH_DEFAULT (4).
//  - One sub-module: iq_ram, a DEPTH x 64 register array.
//    - One synchronous write port (we, waddr, wdata).
//    - One asynchronous read port (raddr, rdata).
//    - Not reset.
//  - inst_queue holds the pointers, count, handshake logic and the bypass mux.
// TESTING
//  1. reset=1 for 2 cycles -> id_valid=0, if_ready=1, iq_count=0, id_inst=0, id_pc=0.
//  2. Push pc 'h3000/'h3004/'h3008 with id_ready=0 -> iq_count=3.
//     Then id_ready=1 -> head pcs 'h3000, 'h3004, 'h3008 on consecutive cycles, then id_valid=0.
//  3. Push 4 with id_ready=0 -> if_ready=0 at count 4.
//     A 5th push of pc 'h3010 is held by fetch.
//     Pop 1 -> if_ready=1 next cycle; 'h3010 is accepted and exits last.
//  4. Wrap-around: push 6 and pop 6 interleaved with id_ready=1 every other cycle.
//     -> order 'h3000..'h3014 preserved; count never exceeds 4.
//  5. Fill 3 entries, then flush=1 with if_valid=1 (pc 'h3100) -> id_valid=0 that cycle.
//     Next cycle count=0; 'h3100 never appears.
//     Push pc 'h1234<<2 -> it is the next head.
//  6. Empty queue, push and pop every cycle:
//     - Bypass undefined: each pc appears 1 cycle after its push.
//     - INST_QUEUE_BYPASS_EN defined: it appears the same cycle with iq_count=0.

Source files
------------

// File: rtl/inst_queue_pkg.sv
// inst_queue_pkg: shared types and constants for the instruction prefetch queue.
//   IQ_NOP            instruction word shown at the head when the queue is empty
//   IQ_DEPTH_DEFAULT  default number of queue entries
//   iq_entry_t        one stored {pc, inst} pair
// The `IQ_NOP / `IQ_DEPTH_DEFAULT macros are provided here for code that uses the
// macro form; the package localparams carry the same values.
`ifndef IQ_NOP
`define IQ_NOP 32'h0000_0000
`endif
`ifndef IQ_DEPTH_DEFAULT
`define IQ_DEPTH_DEFAULT 4
`endif

package inst_queue_pkg;
  localparam logic [31:0] IQ_NOP           = `IQ_NOP;
  localparam int          IQ_DEPTH_DEFAULT = `IQ_DEPTH_DEFAULT;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } iq_entry_t;
endpackage

// File: rtl/iq_ram.sv
// iq_ram: DEPTH x 64 register array holding queued {pc, inst} pairs.
//   clk    in   clock; write on posedge
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   asynchronous read address
//   rdata  out  asynchronous read data
// Contents are not reset; the queue pointers decide what is valid.
module iq_ram
  import inst_queue_pkg::*;
#(
  parameter int DEPTH  = IQ_DEPTH_DEFAULT,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  iq_entry_t         wdata,
  input  logic [ADDR_W-1:0] raddr,
  output iq_entry_t         rdata
);
  iq_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/inst_queue.sv
// inst_queue: prefetch buffer between fetch and decode, valid/ready on both sides.
//   clk, reset      clock; synchronous active-high reset
//   flush           redirect: drop all entries and any push this cycle
//   if_valid/if_pc/if_inst/if_ready   fetch side push handshake
//   id_valid/id_pc/id_inst/id_ready   decode side pop handshake
//   iq_count        occupancy 0..DEPTH
// Optional feature macro INST_QUEUE_BYPASS_EN: when empty, a fetched pair is shown to
// decode in the same cycle; if decode takes it, it is never written.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter  int DEPTH  = IQ_DEPTH_DEFAULT,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            if_valid,
  input  logic [31:0]     if_pc,
  input  logic [31:0]     if_inst,
  output logic            if_ready,
  output logic            id_valid,
  output logic [31:0]     id_pc,
  output logic [31:0]     id_inst,
  input  logic            id_ready,
  output logic [ADDR_W:0] iq_count
);
  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count;
  logic              not_empty, bypass, push, wr_en, pop_mem;
  iq_entry_t         head, wdata;

  assign not_empty = (count != '0);

`ifdef INST_QUEUE_BYPASS_EN
  assign bypass = ~not_empty & if_valid & ~flush;
`else
  assign bypass = 1'b0;
`endif

  // Full refuses pushes even if decode pops this cycle (keeps if_ready off id_ready).
  assign if_ready = (count != FULL);
  assign push     = if_valid & if_ready & ~flush;
  // A bypassed pair taken by decode never lands in storage.
  assign wr_en    = push & ~(bypass & id_ready);
  assign pop_mem  = not_empty & ~flush & id_ready;

  assign id_valid = (not_empty & ~flush) | bypass;
  assign wdata    = '{pc: if_pc, inst: if_inst};

  always_comb begin
    id_pc   = 32'h0;
    id_inst = IQ_NOP;
    if (bypass) begin
      id_pc   = if_pc;
      id_inst = if_inst;
    end else if (id_valid) begin
      id_pc   = head.pc;
      id_inst = head.inst;
    end
  end

  assign iq_count = count;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en)   wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop_mem) rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({wr_en, pop_mem})
        2'b10:   count <= count + (ADDR_W+1)'(1);
        2'b01:   count <= count - (ADDR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  iq_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (head)
  );
endmodule

// File: tb/tb_inst_queue.sv
// tb_inst_queue: directed scenario bench for inst_queue (DEPTH=4).
module tb_inst_queue;
  logic        clk = 1'b0;
  logic        reset, flush, if_valid, id_ready;
  logic [31:0] if_pc, if_inst;
  logic        if_ready, id_valid;
  logic [31:0] id_pc, id_inst;
  logic [2:0]  iq_count;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inst_queue dut (
    .clk(clk), .reset(reset), .flush(flush),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .if_ready(if_ready),
    .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst), .id_ready(id_ready),
    .iq_count(iq_count)
  );

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic drive_if(input logic v, input logic [31:0] pc);
    if_valid = v; if_pc = pc; if_inst = inst_of(pc);
  endtask

  task automatic do_reset();
    reset = 1'b1; flush = 1'b0; id_ready = 1'b0; drive_if(1'b0, 32'h0);
    cyc(); cyc();
    reset = 1'b0; #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_id_valid got %0b want 0", id_valid); end
    checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL reset_if_ready got %0b want 1", if_ready); end
    checks++; if (iq_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", iq_count); end
    checks++; if (id_inst !== 32'h0) begin errors++; $display("FAIL reset_id_inst got %h want 0", id_inst); end
    checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL reset_id_pc got %h want 0", id_pc); end
  endtask

  task automatic test_fifo();
    for (int i = 0; i < 3; i++) begin drive_if(1'b1, 32'h3000 + 32'(4*i)); cyc(); end
    drive_if(1'b0, 32'h0); #1;
    checks++; if (iq_count !== 3'd3) begin errors++; $display("FAIL fifo_count got %0d want 3", iq_count); end
    id_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (id_valid !== 1'b1 || id_pc !== 32'h3000 + 32'(4*i) || id_inst !== inst_of(32'h3000 + 32'(4*i))) begin
        errors++; $display("FAIL fifo_head%0d got v=%0b pc=%h inst=%h want pc=%h", i, id_valid, id_pc, id_inst, 32'h3000 + 32'(4*i));
      end
      cyc();
    end
    checks++; if (id_valid !== 1'b0 || iq_count !== 3'd0) begin errors++; $display("FAIL fifo_drained got v=%0b cnt=%0d want 0/0", id_valid, iq_count); end
    id_ready = 1'b0;
  endtask

  task automatic test_full();
    logic [31:0] want;
    do_reset();
    for (int i = 0; i < 4; i++) begin drive_if(1'b1, 32'h3000 + 32'(4*i)); cyc(); end
    drive_if(1'b1, 32'h3010); #1;
    checks++; if (if_ready !== 1'b0 || iq_count !== 3'd4) begin errors++; $display("FAIL full_ready got rdy=%0b cnt=%0d want 0/4", if_ready, iq_count); end
    cyc();
    checks++; if (iq_count !== 3'd4) begin errors++; $display("FAIL full_hold got cnt=%0d want 4", iq_count); end
    id_ready = 1'b1; #1;
    checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL full_pop_ready got %0b want 0", if_ready); end
    cyc();
    id_ready = 1'b0; #1;
    checks++; if (if_ready !== 1'b1 || iq_count !== 3'd3) begin errors++; $display("FAIL full_after_pop got rdy=%0b cnt=%0d want 1/3", if_ready, iq_count); end
    cyc();
    drive_if(1'b0, 32'h0); #1;
    checks++; if (iq_count !== 3'd4) begin errors++; $display("FAIL full_refill got cnt=%0d want 4", iq_count); end
    id_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1; want = 32'h3000 + 32'(4*i);
      checks++; if (id_valid !== 1'b1 || id_pc !== want) begin errors++; $display("FAIL full_order%0d got v=%0b pc=%h want %h", i, id_valid, id_pc, want); end
      cyc();
    end
    id_ready = 1'b0;
  endtask

  task automatic test_wrap();
    int npush = 0, npop = 0, maxc = 0, cyc_n = 0;
    logic [31:0] want;
    while (npop < 6 && cyc_n < 60) begin
      if (npush < 6) drive_if(1'b1, 32'h3000 + 32'(4*npush)); else drive_if(1'b0, 32'h0);
      id_ready = cyc_n[0];
      #1;
      if (id_valid && id_ready) begin
        want = 32'h3000 + 32'(4*npop);
        checks++; if (id_pc !== want) begin errors++; $display("FAIL wrap_order%0d got %h want %h", npop, id_pc, want); end
        npop++;
      end
      if (if_valid && if_ready) npush++;
      cyc();
      if (int'(iq_count) > maxc) maxc = int'(iq_count);
      cyc_n++;
    end
    drive_if(1'b0, 32'h0); id_ready = 1'b0; #1;
    checks++; if (npop !== 6) begin errors++; $display("FAIL wrap_timeout got %0d pops want 6", npop); end
    checks++; if (maxc > 4) begin errors++; $display("FAIL wrap_maxcount got %0d want <=4", maxc); end
    checks++; if (iq_count !== 3'd0) begin errors++; $display("FAIL wrap_end_count got %0d want 0", iq_count); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 3; i++) begin drive_if(1'b1, 32'h3000 + 32'(4*i)); cyc(); end
    flush = 1'b1; drive_if(1'b1, 32'h3100); id_ready = 1'b1; #1;
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL flush_id_valid got %0b want 0", id_valid); end
    cyc();
    flush = 1'b0; drive_if(1'b0, 32'h0); id_ready = 1'b0; #1;
    checks++; if (iq_count !== 3'd0 || id_valid !== 1'b0 || if_ready !== 1'b1) begin
      errors++; $display("FAIL flush_after got cnt=%0d v=%0b rdy=%0b want 0/0/1", iq_count, id_valid, if_ready);
    end
    drive_if(1'b1, 32'h1234 << 2); cyc();
    drive_if(1'b0, 32'h0); id_ready = 1'b1; #1;
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h48D0) begin errors++; $display("FAIL flush_next_head got v=%0b pc=%h want 48d0", id_valid, id_pc); end
    cyc();
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL flush_no_3100 got v=%0b pc=%h want empty", id_valid, id_pc); end
    id_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 2; i++) begin drive_if(1'b1, 32'h7000 + 32'(4*i)); cyc(); end
    reset = 1'b1; flush = 1'b1; cyc();
    reset = 1'b0; flush = 1'b0; drive_if(1'b0, 32'h0); #1;
    checks++; if (iq_count !== 3'd0 || id_valid !== 1'b0 || id_pc !== 32'h0) begin
      errors++; $display("FAIL reset_mid got cnt=%0d v=%0b pc=%h want 0/0/0", iq_count, id_valid, id_pc);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pc;
    do_reset();
    id_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pc = 32'h5000 + 32'(4*i);
      drive_if(1'b1, pc); #1;
`ifdef INST_QUEUE_BYPASS_EN
      checks++; if (id_valid !== 1'b1 || id_pc !== pc || iq_count !== 3'd0) begin
        errors++; $display("FAIL b2b_bypass%0d got v=%0b pc=%h cnt=%0d want %h/0", i, id_valid, id_pc, iq_count, pc);
      end
`else
      if (i == 0) begin
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL b2b_first got v=%0b want 0", id_valid); end
      end else begin
        checks++; if (id_valid !== 1'b1 || id_pc !== pc - 32'd4 || iq_count !== 3'd1) begin
          errors++; $display("FAIL b2b_lat%0d got v=%0b pc=%h cnt=%0d want %h/1", i, id_valid, id_pc, iq_count, pc - 32'd4);
        end
      end
`endif
      cyc();
    end
    drive_if(1'b0, 32'h0); cyc(); id_ready = 1'b0; #1;
    checks++; if (iq_count !== 3'd0) begin errors++; $display("FAIL b2b_drain got cnt=%0d want 0", iq_count); end
  endtask

  initial begin
    test_reset();
    test_fifo();
    test_full();
    test_wrap();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
